// File: rtl/dma_done_monitor.sv
// dma_done_monitor: per-channel DMA completion flags, saturating event counters and LED stretchers.
// Optional per-channel watchdog (arm/timeout ports) is compiled in with DONE_MON_TIMEOUT_EN.
module dma_done_monitor #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int STRETCH     = 25000000,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NUM_CH-1:0] done_in,
    input  logic [NUM_CH-1:0] clr,
    input  logic [SEL_W-1:0]  rd_sel,
`ifdef DONE_MON_TIMEOUT_EN
    input  logic [NUM_CH-1:0] arm,
    output logic [NUM_CH-1:0] timeout,
`endif
    output logic [CNT_W-1:0]  rd_count,
    output logic [NUM_CH-1:0] sticky,
    output logic [NUM_CH-1:0] led,
    output logic              any_done
);
    localparam int               STR_W   = $clog2(STRETCH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef DONE_MON_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    // Expiry is taken on the edge where the timer would step to TIMEOUT_CYC-1.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 2);

    typedef enum logic {
        WD_IDLE,
        WD_RUN
    } wd_state_t;
`endif

    logic [NUM_CH-1:0]            d_q_reg;
    logic [NUM_CH-1:0]            rise;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_vec;

    assign rise     = done_in & ~d_q_reg;
    assign any_done = |sticky;

    // All-ones after reset so a strobe already high at release is not an event.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            d_q_reg <= '1;
        end else begin
            d_q_reg <= done_in;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_count <= '0;
        end else if (int'(rd_sel) < NUM_CH) begin
            rd_count <= cnt_vec[rd_sel];
        end else begin
            rd_count <= '0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             sticky_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [STR_W-1:0] str_reg;

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    sticky_reg <= 1'b0;
                    cnt_reg    <= '0;
                    str_reg    <= '0;
                end else begin
                    if (rise[gi]) begin
                        sticky_reg <= 1'b1;
                    end else if (clr[gi]) begin
                        sticky_reg <= 1'b0;
                    end

                    if (clr[gi]) begin
                        cnt_reg <= rise[gi] ? CNT_W'(1) : '0;
                    end else if (rise[gi] && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end

                    // Reload rather than accumulate: on-time runs from the latest event.
                    if (rise[gi]) begin
                        str_reg <= STR_W'(STRETCH);
                    end else if (str_reg != '0) begin
                        str_reg <= str_reg - 1'b1;
                    end
                end
            end

            assign sticky[gi]  = sticky_reg;
            assign led[gi]     = (str_reg != '0);
            assign cnt_vec[gi] = cnt_reg;

`ifdef DONE_MON_TIMEOUT_EN
            wd_state_t        wd_state_reg;
            logic [TMR_W-1:0] tmr_reg;
            logic             timeout_reg;

            always_ff @(posedge CLOCK_50) begin
                if (reset || clr[gi]) begin
                    wd_state_reg <= WD_IDLE;
                    tmr_reg      <= '0;
                    timeout_reg  <= 1'b0;
                end else if (arm[gi]) begin
                    wd_state_reg <= WD_RUN;
                    tmr_reg      <= '0;
                    timeout_reg  <= 1'b0;
                end else if (wd_state_reg == WD_RUN) begin
                    if (rise[gi]) begin
                        wd_state_reg <= WD_IDLE;
                    end else if (tmr_reg == TMR_LAST) begin
                        wd_state_reg <= WD_IDLE;
                        timeout_reg  <= 1'b1;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end
            end

            assign timeout[gi] = timeout_reg;
`else
            // Watchdog not built: the channel has no arm/timeout path.
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dma_done_monitor.sv
// Bench for dma_done_monitor: event-history model checked every cycle plus directed literal checks.
// Exercises the watchdog only when built with DONE_MON_TIMEOUT_EN.
module tb_dma_done_monitor;
    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 4;
    localparam int STRETCH     = 5;
    localparam int TIMEOUT_CYC = 10;
    localparam int SEL_W       = 2;
    localparam int AGE_IDLE    = 1 << 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] done_in;
    logic [NUM_CH-1:0] clr;
    logic [SEL_W-1:0]  rd_sel;
    logic [NUM_CH-1:0] arm;
    logic [CNT_W-1:0]  rd_count;
    logic [NUM_CH-1:0] sticky;
    logic [NUM_CH-1:0] led;
    logic              any_done;
    logic [NUM_CH-1:0] timeout;

    always #5 clk = ~clk;

    dma_done_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STRETCH(STRETCH),
        .TIMEOUT_CYC(TIMEOUT_CYC), .SEL_W(SEL_W)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .done_in(done_in),
        .clr(clr),
        .rd_sel(rd_sel),
`ifdef DONE_MON_TIMEOUT_EN
        .arm(arm),
        .timeout(timeout),
`endif
        .rd_count(rd_count),
        .sticky(sticky),
        .led(led),
        .any_done(any_done)
    );

`ifndef DONE_MON_TIMEOUT_EN
    assign timeout = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    bit started = 1'b0;

    // Model state: event history per channel, not register images.
    bit m_prev[NUM_CH];
    bit m_sticky[NUM_CH];
    int m_cnt[NUM_CH];
    int m_age[NUM_CH];
    int m_start[NUM_CH];
    bit m_to[NUM_CH];
    int m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic model_step();
        bit r;
        edge_n++;
        if (reset) begin
            m_rd = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_prev[i]   = 1'b1;
                m_sticky[i] = 1'b0;
                m_cnt[i]    = 0;
                m_age[i]    = AGE_IDLE;
                m_start[i]  = -1;
                m_to[i]     = 1'b0;
            end
        end else begin
            m_rd = (int'(rd_sel) < NUM_CH) ? m_cnt[rd_sel] : 0;
            for (int i = 0; i < NUM_CH; i++) begin
                r = done_in[i] && !m_prev[i];
                m_prev[i] = done_in[i];
                if (r) m_sticky[i] = 1'b1;
                else if (clr[i]) m_sticky[i] = 1'b0;
                if (clr[i]) m_cnt[i] = r ? 1 : 0;
                else if (r) m_cnt[i] = (m_cnt[i] + 1 > 15) ? 15 : m_cnt[i] + 1;
                if (r) m_age[i] = 0;
                else if (m_age[i] < AGE_IDLE) m_age[i]++;
                if (clr[i]) begin
                    m_start[i] = -1;
                    m_to[i]    = 1'b0;
                end else if (arm[i]) begin
                    m_start[i] = edge_n;
                    m_to[i]    = 1'b0;
                end else if (m_start[i] >= 0) begin
                    if (r) m_start[i] = -1;
                    else if (edge_n - m_start[i] == TIMEOUT_CYC - 1) begin
                        m_to[i]    = 1'b1;
                        m_start[i] = -1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    always @(negedge clk) begin
        logic [NUM_CH-1:0] e_st;
        logic [NUM_CH-1:0] e_led;
        logic [NUM_CH-1:0] e_to;
        if (started) begin
            for (int i = 0; i < NUM_CH; i++) begin
                e_st[i]  = m_sticky[i];
                e_led[i] = (m_age[i] < STRETCH);
                e_to[i]  = m_to[i];
            end
            chk("sticky", 32'(sticky), 32'(e_st));
            chk("led", 32'(led), 32'(e_led));
            chk("any_done", 32'(any_done), 32'(|e_st));
            chk("rd_count", 32'(rd_count), 32'(m_rd));
`ifdef DONE_MON_TIMEOUT_EN
            chk("timeout", 32'(timeout), 32'(e_to));
`endif
        end
    end

    initial begin
        reset   = 1'b1;
        done_in = 4'b0001;
        clr     = '0;
        rd_sel  = '0;
        arm     = '0;
        tick();
        started = 1'b1;
        ticks(2);

        // Strobe already high at reset release is not an event.
        reset = 1'b0;
        ticks(3);
        chk("lit_rst_sticky", 32'(sticky), 32'h0);
        chk("lit_rst_led", 32'(led), 32'h0);
        chk("lit_rst_cnt0", 32'(rd_count), 32'h0);
        done_in = '0;
        tick();

        // Single-cycle pulse on channel 1.
        rd_sel  = 2'd1;
        done_in = 4'b0010;
        tick();
        done_in = '0;
        chk("lit_p1_sticky1", 32'(sticky[1]), 32'h1);
        chk("lit_p1_led1_on", 32'(led[1]), 32'h1);
        chk("lit_p1_any", 32'(any_done), 32'h1);
        chk("lit_p1_rd_lat", 32'(rd_count), 32'h0);
        tick();
        chk("lit_p1_rd", 32'(rd_count), 32'h1);
        ticks(3);
        chk("lit_p1_led1_last", 32'(led[1]), 32'h1);
        tick();
        chk("lit_p1_led1_off", 32'(led[1]), 32'h0);

        // Twenty pulses on channel 2 saturate the counter.
        rd_sel = 2'd2;
        for (int p = 0; p < 20; p++) begin
            done_in = 4'b0100;
            tick();
            done_in = '0;
            tick();
        end
        chk("lit_sat_rd", 32'(rd_count), 32'hf);
        chk("lit_sat_sticky2", 32'(sticky[2]), 32'h1);
        clr     = 4'b0100;
        done_in = 4'b0100;
        tick();
        clr     = '0;
        done_in = '0;
        chk("lit_clr_rise_sticky2", 32'(sticky[2]), 32'h1);
        tick();
        chk("lit_clr_rise_cnt2", 32'(rd_count), 32'h1);

        // Channel 3: second event three edges later extends the on-time.
        rd_sel  = 2'd3;
        done_in = 4'b1000;
        tick();
        done_in = '0;
        ticks(2);
        done_in = 4'b1000;
        tick();
        done_in = '0;
        ticks(4);
        chk("lit_ext_led3_on", 32'(led[3]), 32'h1);
        tick();
        chk("lit_ext_led3_off", 32'(led[3]), 32'h0);
        chk("lit_ext_cnt3", 32'(rd_count), 32'h2);

        // Out-of-range select is not possible at NUM_CH=4; clear channel 3 instead.
        clr = 4'b1000;
        tick();
        clr = '0;
        tick();
        chk("lit_clr_cnt3", 32'(rd_count), 32'h0);

`ifdef DONE_MON_TIMEOUT_EN
        // Watchdog expiry, completion before expiry, and arm winning over rise.
        arm = 4'b0001;
        tick();
        arm = '0;
        ticks(TIMEOUT_CYC - 2);
        chk("lit_wd_before", 32'(timeout[0]), 32'h0);
        tick();
        chk("lit_wd_expire", 32'(timeout[0]), 32'h1);
        arm = 4'b0001;
        tick();
        arm = '0;
        chk("lit_wd_rearm_clr", 32'(timeout[0]), 32'h0);
        ticks(3);
        done_in = 4'b0001;
        tick();
        done_in = '0;
        ticks(12);
        chk("lit_wd_done_ok", 32'(timeout[0]), 32'h0);
        arm     = 4'b0001;
        done_in = 4'b0001;
        tick();
        arm     = '0;
        done_in = '0;
        ticks(TIMEOUT_CYC - 2);
        chk("lit_wd_armwin_before", 32'(timeout[0]), 32'h0);
        tick();
        chk("lit_wd_armwin_expire", 32'(timeout[0]), 32'h1);
`endif

        // Reset mid-operation overrides every other input.
        rd_sel  = 2'd1;
        done_in = 4'b0010;
        tick();
        done_in = '0;
        tick();
        reset   = 1'b1;
        done_in = 4'b1111;
        clr     = 4'b0000;
        tick();
        chk("lit_mid_sticky", 32'(sticky), 32'h0);
        chk("lit_mid_led", 32'(led), 32'h0);
        chk("lit_mid_any", 32'(any_done), 32'h0);
        chk("lit_mid_rd", 32'(rd_count), 32'h0);
        chk("lit_mid_to", 32'(timeout), 32'h0);
        reset = 1'b0;
        ticks(2);
        chk("lit_post_sticky", 32'(sticky), 32'h0);
        done_in = '0;
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
